// File: rtl/mmio_bridge_pkg.sv
// Shared types for the MMIO bridge read path: scheduler state, read sideband and flush data.
package mmio_bridge_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StFlush
  } mmio_rd_state_e;

  // Completion sideband; the Tx tag tracker stores the same record.
  typedef struct packed {
    logic [9:0]  tag;
    logic [13:0] length;
    logic [15:0] req_id;
    logic [23:0] low_addr;
  } mmio_rd_sb_t;

  localparam int unsigned MmioFlushMaxWidth = 1024;
  localparam logic [MmioFlushMaxWidth-1:0] MMIO_FLUSH_DATA = '1;

endpackage

// File: rtl/mmio_rd_credit_ctr.sv
// Outstanding-read counter; saturates at MaxCount and at zero, exposes next value and flags.
module mmio_rd_credit_ctr #(
  parameter int unsigned MaxCount = 64,
  parameter int unsigned CntW     = $clog2(MaxCount + 1)
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            inc_i,
  input  logic            dec_i,
  output logic [CntW-1:0] count_o,
  output logic [CntW-1:0] count_next_o,
  output logic            full_next_o,
  output logic            empty_o
);

  localparam logic [CntW-1:0] MaxVal = CntW'(MaxCount);

  logic [CntW-1:0] count_q, count_d;
  logic            full, do_inc, do_dec;

  assign full    = (count_q == MaxVal);
  assign empty_o = (count_q == '0);
  // A simultaneous inc/dec is a no-op, so it is allowed even at the rails.
  assign do_inc  = inc_i && !(full && !dec_i);
  assign do_dec  = dec_i && !(empty_o && !inc_i);

  always_comb begin
    count_d = count_q;
    case ({do_inc, do_dec})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o      = count_q;
  assign count_next_o = count_d;
  assign full_next_o  = (count_d == MaxVal);

endmodule

// File: rtl/mmio_rd_scheduler.sv
// Issues one AVMM read at a time, caps reads in flight, strobes the completion sideband on
// acceptance and flushes all-ones completions when responses stop arriving.
module mmio_rd_scheduler
  import mmio_bridge_pkg::*;
#(
  parameter int unsigned AVMM_ADDR_WIDTH = 18,
  parameter int unsigned AVMM_DATA_WIDTH = 64,
  parameter int unsigned MAX_OUTSTANDING = 64,
  parameter int unsigned TIMEOUT_CYCLES  = 4096,
  parameter int unsigned CNT_W           = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       req_valid_i,
  output logic                       req_ready_o,
  input  logic [AVMM_ADDR_WIDTH-1:0] req_addr_i,
  input  logic [9:0]                 req_tag_i,
  input  logic [13:0]                req_length_i,
  input  logic [15:0]                req_req_id_i,
  input  logic [23:0]                req_low_addr_i,
  output logic                       avmm_m2s_read_o,
  output logic [AVMM_ADDR_WIDTH-1:0] avmm_m2s_address_o,
  input  logic                       avmm_m2s_waitrequest_i,
  input  logic                       avmm_s2m_readdatavalid_i,
  input  logic [AVMM_DATA_WIDTH-1:0] avmm_s2m_readdata_i,
  output logic                       tlp_rd_strb_o,
  output logic [9:0]                 tlp_rd_tag_o,
  output logic [13:0]                tlp_rd_length_o,
  output logic [15:0]                tlp_rd_req_id_o,
  output logic [23:0]                tlp_rd_low_addr_o,
  output logic                       cpl_readdatavalid_o,
  output logic [AVMM_DATA_WIDTH-1:0] cpl_readdata_o,
  output logic [CNT_W-1:0]           outstanding_o,
  output logic                       timeout_err_o,
  input  logic                       clr_err_i
);

  localparam int unsigned TimerW = $clog2(TIMEOUT_CYCLES);
  localparam logic [TimerW-1:0] TimerMax = TimerW'(TIMEOUT_CYCLES - 1);
  localparam logic [AVMM_DATA_WIDTH-1:0] FlushData = MMIO_FLUSH_DATA[AVMM_DATA_WIDTH-1:0];

  mmio_rd_state_e             state_q;
  logic                       ready_q, read_q, strb_q, cpl_valid_q, err_q;
  logic [AVMM_ADDR_WIDTH-1:0] addr_q;
  mmio_rd_sb_t                sb_hold_q, sb_out_q;
  logic [AVMM_DATA_WIDTH-1:0] cpl_data_q;
  logic [TimerW-1:0]          timer_q;

  logic [CNT_W-1:0] cnt_q, cnt_next;
  logic             full_next, empty;
  logic             hs, accept, rsp_real, rsp_flush, cpl_valid_d;
  logic             timer_clear, fire;

  assign hs          = ready_q && req_valid_i;
  assign accept      = read_q && !avmm_m2s_waitrequest_i;
  // Responses with nothing in flight cannot belong to any tag, so they are dropped.
  assign rsp_real    = (state_q != StFlush) && avmm_s2m_readdatavalid_i && !empty;
  assign rsp_flush   = (state_q == StFlush) && !empty;
  assign cpl_valid_d = rsp_real || rsp_flush;

  assign timer_clear = (state_q == StFlush) || empty || avmm_s2m_readdatavalid_i;
  // A handshake or acceptance this cycle defers the timeout by holding the timer at its max.
  assign fire        = !timer_clear && (timer_q == TimerMax) && !hs && !accept;

  mmio_rd_credit_ctr #(
    .MaxCount (MAX_OUTSTANDING),
    .CntW     (CNT_W)
  ) u_credit_ctr (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .inc_i        (accept),
    .dec_i        (cpl_valid_d),
    .count_o      (cnt_q),
    .count_next_o (cnt_next),
    .full_next_o  (full_next),
    .empty_o      (empty)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= StIdle;
      ready_q     <= 1'b0;
      read_q      <= 1'b0;
      addr_q      <= '0;
      sb_hold_q   <= '0;
      sb_out_q    <= '0;
      strb_q      <= 1'b0;
      cpl_valid_q <= 1'b0;
      cpl_data_q  <= '0;
      timer_q     <= '0;
      err_q       <= 1'b0;
    end else begin
      strb_q <= accept;
      if (accept) sb_out_q <= sb_hold_q;

      cpl_valid_q <= cpl_valid_d;
      if (cpl_valid_d) cpl_data_q <= rsp_flush ? FlushData : avmm_s2m_readdata_i;

      if (timer_clear || fire) begin
        timer_q <= '0;
      end else if (timer_q != TimerMax) begin
        timer_q <= timer_q + TimerW'(1);
      end

      if (fire) begin
        err_q <= 1'b1;
      end else if (clr_err_i) begin
        err_q <= 1'b0;
      end

      case (state_q)
        StIdle: begin
          if (hs) begin
            addr_q    <= req_addr_i;
            sb_hold_q <= '{tag: req_tag_i, length: req_length_i,
                           req_id: req_req_id_i, low_addr: req_low_addr_i};
            read_q    <= 1'b1;
            ready_q   <= 1'b0;
            state_q   <= StIssue;
          end else if (fire) begin
            ready_q <= 1'b0;
            state_q <= StFlush;
          end else begin
            ready_q <= !full_next;
          end
        end
        StIssue: begin
          if (accept) begin
            read_q  <= 1'b0;
            ready_q <= !full_next;
            state_q <= StIdle;
          end else if (fire) begin
            read_q  <= 1'b0;
            state_q <= StFlush;
          end
        end
        StFlush: begin
          if (cnt_next == '0) begin
            ready_q <= 1'b1;
            state_q <= StIdle;
          end
        end
        default: begin
          read_q  <= 1'b0;
          ready_q <= 1'b0;
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign req_ready_o         = ready_q;
  assign avmm_m2s_read_o     = read_q;
  assign avmm_m2s_address_o  = addr_q;
  assign tlp_rd_strb_o       = strb_q;
  assign tlp_rd_tag_o        = sb_out_q.tag;
  assign tlp_rd_length_o     = sb_out_q.length;
  assign tlp_rd_req_id_o     = sb_out_q.req_id;
  assign tlp_rd_low_addr_o   = sb_out_q.low_addr;
  assign cpl_readdatavalid_o = cpl_valid_q;
  assign cpl_readdata_o      = cpl_data_q;
  assign outstanding_o       = cnt_q;
  assign timeout_err_o       = err_q;

endmodule

// File: doc/mmio_rd_scheduler.md
# mmio_rd_scheduler

Read-request scheduler between the Rx MMIO bridge's decoded read requests and the AVMM read port, feeding the Tx MMIO bridge's completion path. It issues one AVMM read at a time. It caps outstanding reads so the Tx response FIFO, which has no backpressure, never overflows. It emits the completion-tag sideband strobe at the moment each read is accepted. A response timeout triggers synthetic all-ones completions, which keep the Tx tag tracker aligned with its responses.

## Interface
Parameters:
- AVMM_ADDR_WIDTH, 18, AVMM read address width
- AVMM_DATA_WIDTH, 64, read data width
- MAX_OUTSTANDING, 64, maximum reads in flight; legal range 1..240
- TIMEOUT_CYCLES, 4096, cycles without a response before FLUSH; minimum 2
- CNT_W, $clog2(MAX_OUTSTANDING+1), outstanding counter width

Ports:
- clk  in  1  sole clock
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  read request valid
- req_ready  out  1  request accepted when req_valid && req_ready
- req_addr  in  AVMM_ADDR_WIDTH  AVMM word address
- req_tag  in  10  TLP tag
- req_length  in  14  byte length
- req_req_id  in  16  requester ID
- req_low_addr  in  24  TLP low address
- avmm_m2s_read  out  1  AVMM read
- avmm_m2s_address  out  AVMM_ADDR_WIDTH  AVMM address
- avmm_m2s_waitrequest  in  1  AVMM stall
- avmm_s2m_readdatavalid  in  1  AVMM response valid
- avmm_s2m_readdata  in  AVMM_DATA_WIDTH  AVMM response data
- tlp_rd_strb  out  1  one-cycle sideband strobe to Tx bridge
- tlp_rd_tag / tlp_rd_length / tlp_rd_req_id / tlp_rd_low_addr  out  10/14/16/24  sideband fields, valid with strobe
- cpl_readdatavalid  out  1  response valid to Tx bridge
- cpl_readdata  out  AVMM_DATA_WIDTH  response data to Tx bridge
- outstanding  out  CNT_W  reads in flight
- timeout_err  out  1  sticky timeout flag
- clr_err  in  1  clears timeout_err

## Operation
- States: IDLE, ISSUE, FLUSH.
- **IDLE**
  - req_ready = (outstanding < MAX_OUTSTANDING).
  - On handshake: capture address and sideband into a holding register; go to ISSUE.
- **ISSUE**
  - avmm_m2s_read = 1 and avmm_m2s_address = held address, stable until !avmm_m2s_waitrequest.
  - Acceptance = read && !waitrequest. On acceptance: outstanding +1, go to IDLE.
- **Outstanding counter**
  - Decrements on each cpl_readdatavalid.
  - Simultaneous increment and decrement leave it unchanged.
  - Never exceeds MAX_OUTSTANDING; never goes below 0.
- **Response path**
  - In IDLE and ISSUE, avmm_s2m_readdatavalid/readdata pass to cpl_* through one register stage.
  - A response arriving while outstanding == 0 is dropped.
- **Timer**
  - Clears when outstanding == 0 or avmm_s2m_readdatavalid = 1; increments otherwise.
  - When the timer reaches TIMEOUT_CYCLES-1: set timeout_err, go to FLUSH. This has priority over a pending ISSUE acceptance only if read is not accepted in the same cycle.
- **FLUSH**
  - req_ready = 0, avmm_m2s_read = 0.
  - Emits cpl_readdatavalid = 1 with cpl_readdata = all ones, one per cycle, decrementing outstanding.
  - Real AVMM responses are discarded.
  - When outstanding reaches 0: go to IDLE, timer cleared.
- **timeout_err**
  - Sticky. Cleared by clr_err when not being set the same cycle; set wins.

## Timing
- Reset (async assert): every output 0, state IDLE, counter 0, timer 0, holding register 0. No synthetic completions are generated. req_ready asserts the first cycle after deassertion.
- Request handshake to avmm_m2s_read: 1 cycle.
- tlp_rd_strb and tlp_rd_* are registered. They assert exactly 1 cycle after acceptance, for 1 cycle; fields are held otherwise.
- avmm_s2m_readdatavalid to cpl_readdatavalid: 1 cycle.
- Back-to-back throughput: one request per 2 cycles with waitrequest low.
- Sideband strobe always precedes its response by at least 1 cycle, which preserves Tx tag-tracker ordering.

## Structure
- Shared package `mmio_bridge_pkg`:
  - State enum `mmio_rd_state_e`.
  - Sideband struct `mmio_rd_sb_t` (tag, length, req_id, low_addr); the Tx bridge tag tracker reuses it.
  - `MMIO_FLUSH_DATA` constant (all ones).
- One sub-module: `mmio_rd_credit_ctr`, the outstanding counter with saturation checks and a full flag.

## Test plan
- Single read: req_addr=0x10, tag=0x3A, waitrequest low; response 3 cycles later with data 0xDEADBEEF. Expect avmm_m2s_read at cycle 1, tlp_rd_strb with tag 0x3A at cycle 2, cpl_readdata 0xDEADBEEF 1 cycle after response, outstanding 0→1→0.
- Waitrequest stall: hold waitrequest high 5 cycles. Expect read and address stable for 6 cycles, a single strobe, req_ready low throughout.
- Credit limit: MAX_OUTSTANDING=4, no responses. Expect 4 accepted reads, then req_ready=0. One response re-enables req_ready the next cycle.
- Timeout: TIMEOUT_CYCLES=16, 3 reads outstanding, no responses. Expect timeout_err at cycle 15 after the last event, 3 consecutive cpl_readdata=all-ones beats, return to IDLE. A late real response is dropped; clr_err clears the flag.
- Simultaneous accept and response: acceptance coincides with cpl_readdatavalid. Expect outstanding unchanged.
- Reset mid-ISSUE: assert rst_n low during a stalled read. Expect all outputs 0 immediately and no tlp_rd_strb after release.
